// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo instruction-side blocks: opcodes,
// instruction field positions and the fetch state encoding.
package tomasulo_pkg;

    localparam int INSTR_W = 32;

    localparam logic [4:0] OP_LOAD = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_BEQ  = 5'b00100;

    // Instruction word field positions (bit indices, inclusive)
    localparam int OPC_HI = 29;
    localparam int OPC_LO = 25;
    localparam int RD_HI  = 24;
    localparam int RD_LO  = 22;
    localparam int RS1_HI = 21;
    localparam int RS1_LO = 19;
    localparam int RS2_HI = 18;
    localparam int RS2_LO = 16;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/iq_fifo.sv
// Synchronous FIFO holding fetched {pc, instruction} entries. Head is read
// combinationally; flush empties the queue in one cycle.
module iq_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Pointer and occupancy tracking; flush returns the queue to empty
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy gates validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == CNT_W'(0));
    assign count = count_r;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: program memory written by the loader, in-order
// fetch into a small FIFO, field decode at the FIFO head and valid/ready
// issue. Taken branches flush the queue and restart fetch at a new PC.
module instr_fetch_queue
    import tomasulo_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int QDEPTH     = 4,
    parameter int PC_W       = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_we,
    input  logic [PC_W-1:0] load_addr,
    input  logic [31:0]     load_data,
    input  logic            start,
    input  logic [PC_W-1:0] prog_len,
    output logic            iss_valid,
    input  logic            iss_ready,
    output logic [PC_W-1:0] iss_pc,
    output logic [4:0]      iss_opcode,
    output logic [2:0]      iss_rd,
    output logic [2:0]      iss_rs1,
    output logic [2:0]      iss_rs2,
    output logic [15:0]     iss_imm,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            busy,
    output logic            done
);

    localparam int AW     = $clog2(IMEM_DEPTH);
    localparam int CNT_W  = $clog2(QDEPTH) + 1;
    localparam int ENT_W  = PC_W + INSTR_W;
    localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(IMEM_DEPTH);

    logic [INSTR_W-1:0] imem_r [IMEM_DEPTH];

    fetch_state_t    state_r;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] len_r;
    logic            busy_r;
    logic            done_r;

    logic               redirect_act_s;
    logic               start_act_s;
    logic               push_s;
    logic               pop_s;
    logic               flush_s;
    logic               full_s;
    logic               empty_s;
    logic [CNT_W-1:0]   count_s;
    logic [ENT_W-1:0]   push_data_s;
    logic [ENT_W-1:0]   head_data_s;
    logic [INSTR_W-1:0] head_instr_s;
    logic [PC_W-1:0]    len_clamp_s;
    logic               load_addr_unused_s;

    // Upper load address bits are discarded: the program image wraps modulo depth
    assign load_addr_unused_s = ^load_addr[PC_W-1:AW];

    // Control decode: redirect outranks start, push and pop
    always_comb begin
        redirect_act_s = redirect_valid && (state_r != ST_IDLE);
        start_act_s    = start && ((state_r == ST_IDLE) || (state_r == ST_DONE))
                         && !redirect_act_s;
        flush_s        = redirect_act_s;
        pop_s          = !empty_s && iss_ready && !redirect_act_s;
        push_s         = (state_r == ST_FETCH) && (pc_r < len_r)
                         && (!full_s || pop_s) && !redirect_act_s;
        push_data_s    = {pc_r, imem_r[pc_r[AW-1:0]]};
        if (prog_len > DEPTH_PC) begin
            len_clamp_s = DEPTH_PC;
        end else begin
            len_clamp_s = prog_len;
        end
    end

    // Program image write port, open only while fetch is not running
    always_ff @(posedge clk) begin
        if (load_we && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
            imem_r[load_addr[AW-1:0]] <= load_data;
        end
    end

    // Fetch state machine with PC/length registers and registered status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            pc_r    <= {PC_W{1'b0}};
            len_r   <= {PC_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (redirect_act_s) begin
            pc_r   <= redirect_pc;
            busy_r <= 1'b1;
            done_r <= 1'b0;
            if (redirect_pc < len_r) begin
                state_r <= ST_FETCH;
            end else begin
                state_r <= ST_DRAIN;
            end
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_act_s) begin
                        pc_r  <= {PC_W{1'b0}};
                        len_r <= len_clamp_s;
                        if (len_clamp_s == {PC_W{1'b0}}) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_FETCH;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_FETCH: begin
                    if (pc_r >= len_r) begin
                        state_r <= ST_DRAIN;
                    end else if (push_s) begin
                        pc_r <= pc_r + PC_W'(1);
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                ST_DRAIN: begin
                    if (count_s == CNT_W'(0)) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    iq_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .wdata (push_data_s),
        .rdata (head_data_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Head decode; fields read as zero whenever the queue is empty
    always_comb begin
        head_instr_s = head_data_s[INSTR_W-1:0];
        if (empty_s) begin
            iss_pc     = {PC_W{1'b0}};
            iss_opcode = 5'd0;
            iss_rd     = 3'd0;
            iss_rs1    = 3'd0;
            iss_rs2    = 3'd0;
            iss_imm    = 16'd0;
        end else begin
            iss_pc     = head_data_s[ENT_W-1:INSTR_W];
            iss_opcode = head_instr_s[OPC_HI:OPC_LO];
            iss_rd     = head_instr_s[RD_HI:RD_LO];
            iss_rs1    = head_instr_s[RS1_HI:RS1_LO];
            iss_rs2    = head_instr_s[RS2_HI:RS2_LO];
            iss_imm    = head_instr_s[IMM_HI:IMM_LO];
        end
    end

    assign iss_valid = !empty_s;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: program load, in-order issue,
// backpressure, redirects, zero-length programs and mid-run reset.
module tb_instr_fetch_queue;
    import tomasulo_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_we;
    logic [15:0] load_addr;
    logic [31:0] load_data;
    logic        start;
    logic [15:0] prog_len;
    logic        iss_valid;
    logic        iss_ready;
    logic [15:0] iss_pc;
    logic [4:0]  iss_opcode;
    logic [2:0]  iss_rd;
    logic [2:0]  iss_rs1;
    logic [2:0]  iss_rs2;
    logic [15:0] iss_imm;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    logic [31:0] prog2 [8];

    instr_fetch_queue #(.IMEM_DEPTH(64), .QDEPTH(4), .PC_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .load_we        (load_we),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .start          (start),
        .prog_len       (prog_len),
        .iss_valid      (iss_valid),
        .iss_ready      (iss_ready),
        .iss_pc         (iss_pc),
        .iss_opcode     (iss_opcode),
        .iss_rd         (iss_rd),
        .iss_rs1        (iss_rs1),
        .iss_rs2        (iss_rs2),
        .iss_imm        (iss_imm),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .done           (done)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic [15:0] imm);
        return {2'b00, op, rd, rs1, rs2, imm};
    endfunction

    task automatic load_word(input logic [15:0] addr, input logic [31:0] data);
        load_we   = 1'b1;
        load_addr = addr;
        load_data = data;
        tick();
        load_we   = 1'b0;
    endtask

    task automatic kick(input logic [15:0] len);
        start    = 1'b1;
        prog_len = len;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 10 && !done; k++) tick();
        check_eq(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; load_we = 1'b0; load_addr = 16'd0; load_data = 32'd0;
        start = 1'b0; prog_len = 16'd0; iss_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 16'd0;
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_valid", {31'd0, iss_valid}, 32'd0);
        check_eq("rst_busy",  {31'd0, busy}, 32'd0);
        check_eq("rst_done",  {31'd0, done}, 32'd0);
        check_eq("rst_pc",    {16'd0, iss_pc}, 32'd0);

        // Three-instruction program, issue stage always ready
        load_word(16'd0, mk(OP_LOAD, 3'd1, 3'd2, 3'd0, 16'd0));
        load_word(16'd1, mk(OP_ADD,  3'd3, 3'd1, 3'd4, 16'd0));
        load_word(16'd2, mk(OP_BEQ,  3'd0, 3'd1, 3'd2, 16'd5));
        iss_ready = 1'b1;
        kick(16'd3);
        check_eq("t1_lat_valid", {31'd0, iss_valid}, 32'd0);
        check_eq("t1_busy", {31'd0, busy}, 32'd1);
        tick();
        check_eq("t1_v0",   {31'd0, iss_valid}, 32'd1);
        check_eq("t1_pc0",  {16'd0, iss_pc}, 32'd0);
        check_eq("t1_op0",  {27'd0, iss_opcode}, 32'h00);
        check_eq("t1_rd0",  {29'd0, iss_rd}, 32'd1);
        check_eq("t1_rs10", {29'd0, iss_rs1}, 32'd2);
        tick();
        check_eq("t1_pc1",  {16'd0, iss_pc}, 32'd1);
        check_eq("t1_op1",  {27'd0, iss_opcode}, 32'h02);
        check_eq("t1_rd1",  {29'd0, iss_rd}, 32'd3);
        check_eq("t1_rs21", {29'd0, iss_rs2}, 32'd4);
        tick();
        check_eq("t1_pc2",  {16'd0, iss_pc}, 32'd2);
        check_eq("t1_op2",  {27'd0, iss_opcode}, 32'h04);
        check_eq("t1_rd2",  {29'd0, iss_rd}, 32'd0);
        check_eq("t1_imm2", {16'd0, iss_imm}, 32'd5);
        tick();
        check_eq("t1_empty", {31'd0, iss_valid}, 32'd0);
        check_eq("t1_drain_done", {31'd0, done}, 32'd0);
        tick();
        check_eq("t1_done", {31'd0, done}, 32'd1);
        check_eq("t1_idle_busy", {31'd0, busy}, 32'd0);

        // Eight-instruction program with a 10-cycle stall
        for (int i = 0; i < 8; i++) begin
            prog2[i] = mk(OP_ADD, 3'(i), 3'd1, 3'd2, 16'(100 + i));
            load_word(16'(i), prog2[i]);
        end
        iss_ready = 1'b0;
        kick(16'd8);
        repeat (10) tick();
        check_eq("t2_hold_valid", {31'd0, iss_valid}, 32'd1);
        check_eq("t2_hold_pc",    {16'd0, iss_pc}, 32'd0);
        check_eq("t2_hold_imm",   {16'd0, iss_imm}, 32'd100);
        iss_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t2_pc%0d", i),  {16'd0, iss_pc}, 32'(i));
            check_eq($sformatf("t2_imm%0d", i), {16'd0, iss_imm}, 32'(100 + i));
            tick();
        end
        check_eq("t2_empty", {31'd0, iss_valid}, 32'd0);
        wait_done("t2_done");

        // Redirect to pc 1 while the queue holds pcs 2 and 3
        iss_ready = 1'b0;
        kick(16'd4);
        repeat (4) tick();
        check_eq("t3_full_head", {16'd0, iss_pc}, 32'd0);
        iss_ready = 1'b1;
        tick();
        tick();
        check_eq("t3_head2", {16'd0, iss_pc}, 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 16'd1;
        tick();
        redirect_valid = 1'b0;
        check_eq("t3_flush_valid", {31'd0, iss_valid}, 32'd0);
        tick();
        check_eq("t3_valid1", {31'd0, iss_valid}, 32'd1);
        check_eq("t3_pc1", {16'd0, iss_pc}, 32'd1);
        tick();
        check_eq("t3_pc2", {16'd0, iss_pc}, 32'd2);
        tick();
        check_eq("t3_pc3", {16'd0, iss_pc}, 32'd3);
        tick();
        check_eq("t3_empty", {31'd0, iss_valid}, 32'd0);
        wait_done("t3_done");

        // Redirect past the end of a length-3 program
        iss_ready = 1'b0;
        kick(16'd3);
        tick();
        tick();
        check_eq("t4_pre_valid", {31'd0, iss_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 16'd5;
        tick();
        redirect_valid = 1'b0;
        check_eq("t4_flush_valid", {31'd0, iss_valid}, 32'd0);
        check_eq("t4_busy", {31'd0, busy}, 32'd1);
        tick();
        check_eq("t4_done", {31'd0, done}, 32'd1);
        iss_ready = 1'b1;
        tick();
        tick();
        check_eq("t4_no_valid", {31'd0, iss_valid}, 32'd0);

        // Program writes are ignored while fetching
        kick(16'd1);
        load_word(16'd0, 32'hFFFF_FFFF);
        wait_done("t5_done");
        kick(16'd1);
        tick();
        check_eq("t5_imem_imm", {16'd0, iss_imm}, {16'd0, prog2[0][15:0]});
        check_eq("t5_imem_rd",  {29'd0, iss_rd}, 32'd0);
        wait_done("t5_done2");

        // Reset mid-fetch, zero-length start, then restart
        kick(16'd8);
        tick();
        tick();
        check_eq("t6_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("t6_rst_valid", {31'd0, iss_valid}, 32'd0);
        check_eq("t6_rst_busy",  {31'd0, busy}, 32'd0);
        check_eq("t6_rst_done",  {31'd0, done}, 32'd0);
        kick(16'd0);
        check_eq("t6_zero_done",  {31'd0, done}, 32'd1);
        check_eq("t6_zero_valid", {31'd0, iss_valid}, 32'd0);
        check_eq("t6_zero_busy",  {31'd0, busy}, 32'd0);
        tick();
        check_eq("t6_zero_valid2", {31'd0, iss_valid}, 32'd0);
        kick(16'd1);
        check_eq("t6_lat_valid", {31'd0, iss_valid}, 32'd0);
        tick();
        check_eq("t6_re_valid", {31'd0, iss_valid}, 32'd1);
        check_eq("t6_re_pc",    {16'd0, iss_pc}, 32'd0);
        check_eq("t6_re_imm",   {16'd0, iss_imm}, 32'd100);
        wait_done("t6_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
